// File: rtl/uart_param_core.sv
// uart_param_core: UART with TX/RX FIFOs, runtime baud divisor, serial pins and error pulses.
// Define UART_PARITY_EN to add a parity bit to both directions (ports parity_odd/parity_err).
module uart_param_core #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                  UCLK,
  input  logic                  reset,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic [DATA_WIDTH-1:0] W_data,
  input  logic                  wr_uart,
  output logic                  tx_full,
  output logic [DATA_WIDTH-1:0] R_data,
  input  logic                  rd_uart,
  output logic                  rx_empty,
  output logic                  tx,
  input  logic                  rx,
  output logic                  frame_err,
`ifdef UART_PARITY_EN
  input  logic                  parity_odd,
  output logic                  parity_err,
`endif
  output logic                  overrun
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int TCW = $clog2(STOP_BITS * OVERSAMPLE) + 1;
  localparam int BCW = $clog2(DATA_WIDTH) + 1;

  localparam logic [TCW-1:0] OS_LAST   = TCW'(OVERSAMPLE - 1);
  localparam logic [TCW-1:0] HALF_LAST = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] STOP_LAST = TCW'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_state_e;

`ifdef UART_PARITY_EN
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
`endif

  // ---------------- baud tick ----------------
  logic [DIV_WIDTH-1:0] tick_cnt_r;
  logic                 tick_s;

  assign tick_s = (tick_cnt_r == baud_div);

  // Divider compares against the live baud_div; an out-of-range count wraps at once
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      tick_cnt_r <= {DIV_WIDTH{1'b0}};
    end else if (tick_cnt_r >= baud_div) begin
      tick_cnt_r <= {DIV_WIDTH{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + DIV_WIDTH'(1);
    end
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_WIDTH-1:0] tx_mem_r [FIFO_DEPTH];
  logic [PW-1:0]         tx_wptr_r, tx_rptr_r;
  logic                  tx_push_s, tx_pop_s, tx_empty_s;
  logic [DATA_WIDTH-1:0] tx_head_s;

  assign tx_empty_s = (tx_wptr_r == tx_rptr_r);
  assign tx_full    = (tx_wptr_r[AW] != tx_rptr_r[AW]) &&
                      (tx_wptr_r[AW-1:0] == tx_rptr_r[AW-1:0]);
  assign tx_push_s  = wr_uart && !tx_full;
  assign tx_head_s  = tx_mem_r[tx_rptr_r[AW-1:0]];

  // TX storage array
  always_ff @(posedge UCLK) begin
    if (tx_push_s) begin
      tx_mem_r[tx_wptr_r[AW-1:0]] <= W_data;
    end
  end

  // TX FIFO pointers
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      tx_wptr_r <= {PW{1'b0}};
      tx_rptr_r <= {PW{1'b0}};
    end else begin
      if (tx_push_s) tx_wptr_r <= tx_wptr_r + PW'(1);
      if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + PW'(1);
    end
  end

  // ---------------- TX FSM ----------------
  uart_state_e           tx_state_r, tx_state_n;
  logic [TCW-1:0]        tx_tcnt_r, tx_tcnt_n;
  logic [BCW-1:0]        tx_bcnt_r, tx_bcnt_n;
  logic [DATA_WIDTH-1:0] tx_shift_r, tx_shift_n;
  logic                  tx_r, tx_n;
`ifdef UART_PARITY_EN
  logic                  tx_par_r, tx_par_n;
`endif

  assign tx = tx_r;

  // TX state register
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      tx_state_r <= ST_IDLE;
      tx_tcnt_r  <= {TCW{1'b0}};
      tx_bcnt_r  <= {BCW{1'b0}};
      tx_shift_r <= {DATA_WIDTH{1'b0}};
      tx_r       <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_r   <= 1'b0;
`endif
    end else begin
      tx_state_r <= tx_state_n;
      tx_tcnt_r  <= tx_tcnt_n;
      tx_bcnt_r  <= tx_bcnt_n;
      tx_shift_r <= tx_shift_n;
      tx_r       <= tx_n;
`ifdef UART_PARITY_EN
      tx_par_r   <= tx_par_n;
`endif
    end
  end

  // TX next state; a frame is loaded from IDLE or straight out of STOP for gapless streaming
  always_comb begin
    tx_state_n = tx_state_r;
    tx_tcnt_n  = tx_tcnt_r;
    tx_bcnt_n  = tx_bcnt_r;
    tx_shift_n = tx_shift_r;
    tx_n       = tx_r;
    tx_pop_s   = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_n   = tx_par_r;
`endif
    if (tick_s) begin
      case (tx_state_r)
        ST_IDLE: begin
          if (!tx_empty_s) begin
            tx_pop_s   = 1'b1;
            tx_shift_n = tx_head_s;
            tx_n       = 1'b0;
            tx_tcnt_n  = {TCW{1'b0}};
            tx_state_n = ST_START;
`ifdef UART_PARITY_EN
            tx_par_n   = calc_parity(tx_head_s, parity_odd);
`endif
          end else begin
            tx_n = 1'b1;
          end
        end
        ST_START: begin
          if (tx_tcnt_r == OS_LAST) begin
            tx_tcnt_n  = {TCW{1'b0}};
            tx_bcnt_n  = {BCW{1'b0}};
            tx_n       = tx_shift_r[0];
            tx_state_n = ST_DATA;
          end else begin
            tx_tcnt_n = tx_tcnt_r + TCW'(1);
          end
        end
        ST_DATA: begin
          if (tx_tcnt_r == OS_LAST) begin
            tx_tcnt_n = {TCW{1'b0}};
            if (tx_bcnt_r == BIT_LAST) begin
`ifdef UART_PARITY_EN
              tx_n       = tx_par_r;
              tx_state_n = ST_PARITY;
`else
              tx_n       = 1'b1;
              tx_state_n = ST_STOP;
`endif
            end else begin
              tx_bcnt_n  = tx_bcnt_r + BCW'(1);
              tx_shift_n = tx_shift_r >> 1;
              tx_n       = tx_shift_r[1];
            end
          end else begin
            tx_tcnt_n = tx_tcnt_r + TCW'(1);
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (tx_tcnt_r == OS_LAST) begin
            tx_tcnt_n  = {TCW{1'b0}};
            tx_n       = 1'b1;
            tx_state_n = ST_STOP;
          end else begin
            tx_tcnt_n = tx_tcnt_r + TCW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (tx_tcnt_r == STOP_LAST) begin
            tx_tcnt_n = {TCW{1'b0}};
            if (!tx_empty_s) begin
              tx_pop_s   = 1'b1;
              tx_shift_n = tx_head_s;
              tx_n       = 1'b0;
              tx_state_n = ST_START;
`ifdef UART_PARITY_EN
              tx_par_n   = calc_parity(tx_head_s, parity_odd);
`endif
            end else begin
              tx_n       = 1'b1;
              tx_state_n = ST_IDLE;
            end
          end else begin
            tx_tcnt_n = tx_tcnt_r + TCW'(1);
          end
        end
        default: begin
          tx_n       = 1'b1;
          tx_state_n = ST_IDLE;
        end
      endcase
    end else begin
      tx_state_n = tx_state_r;
    end
  end

  // ---------------- RX synchroniser ----------------
  logic [1:0] rx_sync_r;
  logic       rx_bit_s;

  assign rx_bit_s = rx_sync_r[1];

  // Two-flop synchroniser, idles high
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      rx_sync_r <= 2'b11;
    end else begin
      rx_sync_r <= {rx_sync_r[0], rx};
    end
  end

  // ---------------- RX FSM ----------------
  uart_state_e           rx_state_r, rx_state_n;
  logic [TCW-1:0]        rx_tcnt_r, rx_tcnt_n;
  logic [BCW-1:0]        rx_bcnt_r, rx_bcnt_n;
  logic [DATA_WIDTH-1:0] rx_shift_r, rx_shift_n;
  logic                  rx_push_s, rx_fe_s;
`ifdef UART_PARITY_EN
  logic                  rx_pbad_r, rx_pbad_n, rx_pe_s;
`endif

  // RX state register
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      rx_state_r <= ST_IDLE;
      rx_tcnt_r  <= {TCW{1'b0}};
      rx_bcnt_r  <= {BCW{1'b0}};
      rx_shift_r <= {DATA_WIDTH{1'b0}};
`ifdef UART_PARITY_EN
      rx_pbad_r  <= 1'b0;
`endif
    end else begin
      rx_state_r <= rx_state_n;
      rx_tcnt_r  <= rx_tcnt_n;
      rx_bcnt_r  <= rx_bcnt_n;
      rx_shift_r <= rx_shift_n;
`ifdef UART_PARITY_EN
      rx_pbad_r  <= rx_pbad_n;
`endif
    end
  end

  // RX next state; the start bit is re-checked at mid-bit to reject glitches
  always_comb begin
    rx_state_n = rx_state_r;
    rx_tcnt_n  = rx_tcnt_r;
    rx_bcnt_n  = rx_bcnt_r;
    rx_shift_n = rx_shift_r;
    rx_push_s  = 1'b0;
    rx_fe_s    = 1'b0;
`ifdef UART_PARITY_EN
    rx_pbad_n  = rx_pbad_r;
    rx_pe_s    = 1'b0;
`endif
    if (tick_s) begin
      case (rx_state_r)
        ST_IDLE: begin
          if (!rx_bit_s) begin
            rx_tcnt_n  = {TCW{1'b0}};
            rx_state_n = ST_START;
          end else begin
            rx_state_n = ST_IDLE;
          end
        end
        ST_START: begin
          if (rx_tcnt_r == HALF_LAST) begin
            rx_tcnt_n = {TCW{1'b0}};
            rx_bcnt_n = {BCW{1'b0}};
            if (rx_bit_s) begin
              rx_state_n = ST_IDLE;
            end else begin
              rx_state_n = ST_DATA;
            end
          end else begin
            rx_tcnt_n = rx_tcnt_r + TCW'(1);
          end
        end
        ST_DATA: begin
          if (rx_tcnt_r == OS_LAST) begin
            rx_tcnt_n  = {TCW{1'b0}};
            rx_shift_n = {rx_bit_s, rx_shift_r[DATA_WIDTH-1:1]};
            if (rx_bcnt_r == BIT_LAST) begin
`ifdef UART_PARITY_EN
              rx_state_n = ST_PARITY;
`else
              rx_state_n = ST_STOP;
`endif
            end else begin
              rx_bcnt_n = rx_bcnt_r + BCW'(1);
            end
          end else begin
            rx_tcnt_n = rx_tcnt_r + TCW'(1);
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (rx_tcnt_r == OS_LAST) begin
            rx_tcnt_n  = {TCW{1'b0}};
            rx_pbad_n  = (rx_bit_s != calc_parity(rx_shift_r, parity_odd));
            rx_state_n = ST_STOP;
          end else begin
            rx_tcnt_n = rx_tcnt_r + TCW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (rx_tcnt_r == OS_LAST) begin
            rx_tcnt_n  = {TCW{1'b0}};
            rx_push_s  = 1'b1;
            rx_fe_s    = !rx_bit_s;
            rx_state_n = ST_IDLE;
`ifdef UART_PARITY_EN
            rx_pe_s    = rx_pbad_r;
`endif
          end else begin
            rx_tcnt_n = rx_tcnt_r + TCW'(1);
          end
        end
        default: begin
          rx_state_n = ST_IDLE;
        end
      endcase
    end else begin
      rx_state_n = rx_state_r;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_WIDTH-1:0] rx_mem_r [FIFO_DEPTH];
  logic [PW-1:0]         rx_wptr_r, rx_rptr_r, rx_count_s;
  logic                  rx_full_s, rx_pop_s, rx_wr_s;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  frame_err_r, overrun_r;

  assign rx_empty   = (rx_wptr_r == rx_rptr_r);
  assign rx_full_s  = (rx_wptr_r[AW] != rx_rptr_r[AW]) &&
                      (rx_wptr_r[AW-1:0] == rx_rptr_r[AW-1:0]);
  assign rx_count_s = rx_wptr_r - rx_rptr_r;
  assign rx_pop_s   = rd_uart && !rx_empty;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the word
  assign rx_wr_s    = rx_push_s && (!rx_full_s || rx_pop_s);
  assign R_data     = rdata_r;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;

  // RX storage array
  always_ff @(posedge UCLK) begin
    if (rx_wr_s) begin
      rx_mem_r[rx_wptr_r[AW-1:0]] <= rx_shift_r;
    end
  end

  // RX pointers, head register and error pulses
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      rx_wptr_r   <= {PW{1'b0}};
      rx_rptr_r   <= {PW{1'b0}};
      rdata_r     <= {DATA_WIDTH{1'b0}};
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      if (rx_wr_s)  rx_wptr_r <= rx_wptr_r + PW'(1);
      if (rx_pop_s) rx_rptr_r <= rx_rptr_r + PW'(1);
      if (rx_pop_s) begin
        if (rx_count_s != PW'(1)) begin
          rdata_r <= rx_mem_r[rx_rptr_r[AW-1:0] + AW'(1)];
        end else if (rx_wr_s) begin
          rdata_r <= rx_shift_r;
        end
      end else if (rx_wr_s && rx_empty) begin
        rdata_r <= rx_shift_r;
      end
      frame_err_r <= rx_fe_s;
      overrun_r   <= rx_push_s && rx_full_s && !rx_pop_s;
    end
  end

`ifdef UART_PARITY_EN
  logic parity_err_r;

  assign parity_err = parity_err_r;

  // Parity mismatch pulse, aligned with the push of the affected word
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      parity_err_r <= 1'b0;
    end else begin
      parity_err_r <= rx_pe_s;
    end
  end
`endif

endmodule

// File: tb/tb_uart_param_core.sv
// Scoreboard bench for uart_param_core: stimulus pushes expected RX words, a monitor pops and compares.
// Default build uses OVERSAMPLE=16 and baud_div=0, i.e. 16 UCLK per bit.
module tb_uart_param_core;

`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic        UCLK = 1'b0;
  logic        reset;
  logic [15:0] baud_div;
  logic [7:0]  W_data;
  logic        wr_uart;
  logic        tx_full;
  logic [7:0]  R_data;
  logic        rd_uart;
  logic        rx_empty;
  logic        tx;
  logic        rx_w;
  logic        frame_err;
  logic        overrun;
`ifdef UART_PARITY_EN
  logic        parity_odd;
  logic        parity_err;
  int          pe_cnt = 0;
`endif

  logic        rx_drv;
  logic        loop_en;
  logic        auto_rd;
  logic [7:0]  exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          fe_cnt = 0;
  int          ov_cnt = 0;
  logic        fe_with_word = 1'b0;

  assign rx_w = loop_en ? tx : rx_drv;

  always #5 UCLK = ~UCLK;

  uart_param_core dut (
    .UCLK      (UCLK),
    .reset     (reset),
    .baud_div  (baud_div),
    .W_data    (W_data),
    .wr_uart   (wr_uart),
    .tx_full   (tx_full),
    .R_data    (R_data),
    .rd_uart   (rd_uart),
    .rx_empty  (rx_empty),
    .tx        (tx),
    .rx        (rx_w),
    .frame_err (frame_err),
`ifdef UART_PARITY_EN
    .parity_odd(parity_odd),
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // bit 0 of the result is the start bit
  function automatic logic [11:0] frame_bits(input logic [7:0] d, input logic stop);
`ifdef UART_PARITY_EN
    return {1'b0, stop, (^d) ^ parity_odd, d, 1'b0};
`else
    return {2'b00, stop, d, 1'b0};
`endif
  endfunction

  task automatic write_word(input logic [7:0] d);
    W_data  = d;
    wr_uart = 1'b1;
    @(negedge UCLK);
    wr_uart = 1'b0;
  endtask

  task automatic check_tx_frame(input string name, input logic [11:0] bits);
    int n = 0;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge UCLK);
      n++;
    end
    check({name, "_start_seen"}, 32'(n < 200), 32'd1);
    repeat (8) @(negedge UCLK);
    for (int i = 0; i < FRAME_BITS; i++) begin
      check($sformatf("%s_bit%0d", name, i), 32'(tx), 32'(bits[i]));
      if (i < FRAME_BITS - 1) repeat (16) @(negedge UCLK);
    end
  endtask

  task automatic drive_rx(input logic [11:0] bits);
    for (int i = 0; i < FRAME_BITS; i++) begin
      rx_drv = bits[i];
      repeat (16) @(negedge UCLK);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge UCLK);
      n++;
    end
    check({name, "_drain_in_time"}, 32'(n < budget), 32'd1);
    repeat (4) @(negedge UCLK);
    check({name, "_rx_empty_after"}, 32'(rx_empty), 32'd1);
  endtask

  // Monitor: whenever the DUT shows a word, compare it with the scoreboard head and pop it
  initial begin
    rd_uart = 1'b0;
    forever begin
      @(negedge UCLK);
      if (auto_rd && reset && !rx_empty) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL rx_word: got %0h, expected no word", R_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (R_data !== e) begin
            fails++;
            $display("FAIL rx_word: got %0h, expected %0h", R_data, e);
          end
        end
        rd_uart = 1'b1;
      end else begin
        rd_uart = 1'b0;
      end
    end
  end

  // Pulse counters
  always @(negedge UCLK) begin
    if (frame_err === 1'b1) begin
      fe_cnt       <= fe_cnt + 1;
      fe_with_word <= !rx_empty;
    end
    if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
`ifdef UART_PARITY_EN
    if (parity_err === 1'b1) pe_cnt <= pe_cnt + 1;
`endif
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, ov0;
    reset    = 1'b0;
    baud_div = 16'd0;
    W_data   = 8'h00;
    wr_uart  = 1'b0;
    rx_drv   = 1'b1;
    loop_en  = 1'b1;
    auto_rd  = 1'b0;
`ifdef UART_PARITY_EN
    parity_odd = 1'b0;
`endif
    repeat (3) @(negedge UCLK);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_full", 32'(tx_full), 32'd0);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_r_data", 32'(R_data), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge UCLK);

    // 1: single word in loopback, serial waveform checked bit by bit
    auto_rd = 1'b1;
    exp_q.push_back(8'hA5);
    write_word(8'hA5);
`ifdef UART_PARITY_EN
    check_tx_frame("a5", frame_bits(8'hA5, 1'b1));
`else
    check_tx_frame("a5", 12'h34A);
`endif
    wait_drain("a5", 400);

    // 2: TX FIFO fills with no ticks; the 17th write is lost
    baud_div = 16'hFFFF;
    for (int i = 0; i < 17; i++) begin
      write_word(8'h10 + 8'(i));
      check($sformatf("tx_full_after_wr%0d", i + 1), 32'(tx_full), 32'(i >= 15));
      if (i < 16) exp_q.push_back(8'h10 + 8'(i));
    end
    baud_div = 16'd0;
    wait_drain("fifo16", 4000);

    // 3: 17 frames without reads; one overrun, head is the first word
    auto_rd = 1'b0;
    ov0 = ov_cnt;
    fe0 = fe_cnt;
    for (int i = 0; i < 17; i++) write_word(8'h40 + 8'(i));
    repeat (17 * 160 + 300) @(negedge UCLK);
    check("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
    check("ovr_not_empty", 32'(rx_empty), 32'd0);
    check("ovr_head", 32'(R_data), 32'h40);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h40 + 8'(i));
    auto_rd = 1'b1;
    wait_drain("ovr", 400);
    check("ovr_no_frame_err", 32'(fe_cnt - fe0), 32'd0);

    // 4: external frame with stop bit 0
    loop_en = 1'b0;
    fe0 = fe_cnt;
    exp_q.push_back(8'h3C);
    drive_rx(frame_bits(8'h3C, 1'b0));
    repeat (100) @(negedge UCLK);
    wait_drain("ferr", 200);
    check("ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
    check("ferr_with_push", 32'(fe_with_word), 32'd1);

    // 5: 4-cycle glitch is rejected, then a clean frame still arrives
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rx_drv = 1'b0;
    repeat (4) @(negedge UCLK);
    rx_drv = 1'b1;
    repeat (200) @(negedge UCLK);
    check("glitch_rx_empty", 32'(rx_empty), 32'd1);
    check("glitch_no_fe", 32'(fe_cnt - fe0), 32'd0);
    check("glitch_no_ovr", 32'(ov_cnt - ov0), 32'd0);
    exp_q.push_back(8'h5A);
    drive_rx(frame_bits(8'h5A, 1'b1));
    wait_drain("after_glitch", 300);

`ifdef UART_PARITY_EN
    // 6: odd parity on 0x01 gives parity bit 0; an injected 1 flags an error
    loop_en = 1'b1;
    parity_odd = 1'b1;
    exp_q.push_back(8'h01);
    write_word(8'h01);
    check_tx_frame("par01", 12'h402);
    wait_drain("par01", 400);
    loop_en = 1'b0;
    fe0 = pe_cnt;
    exp_q.push_back(8'h01);
    drive_rx(12'h602);
    wait_drain("perr", 300);
    check("perr_pulses", 32'(pe_cnt - fe0), 32'd1);
`endif

    // Reset in the middle of a data bit
    loop_en = 1'b1;
    write_word(8'h77);
    repeat (50) @(negedge UCLK);
    reset = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_tx_full", 32'(tx_full), 32'd0);
    check("midrst_rx_empty", 32'(rx_empty), 32'd1);
    check("midrst_r_data", 32'(R_data), 32'd0);
    repeat (3) @(negedge UCLK);
    reset = 1'b1;
    repeat (300) @(negedge UCLK);
    check("midrst_idle_tx", 32'(tx), 32'd1);
    check("midrst_nothing_rx", 32'(rx_empty), 32'd1);
    exp_q.push_back(8'h81);
    write_word(8'h81);
    wait_drain("post_rst", 400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
